// File: rtl/z80fi_insn_capture.sv
// z80fi_insn_capture: assembles one Z80FI retirement record per instruction from core strobes
module z80fi_insn_capture #(
    parameter int MAX_MCYCLES    = 6,
    parameter int MAX_INSN_BYTES = 4
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        instr_start,
    input  logic                        instr_retire,
    input  logic                        mcycle_start,
    input  logic [2:0]                  mcycle_type,
    input  logic                        tstate_tick,
    input  logic                        insn_byte_valid,
    input  logic [7:0]                  insn_byte,
    input  logic [7:0]                  reg_a,
    input  logic [7:0]                  reg_f,
    input  logic [15:0]                 reg_ip,
    output logic                        z80fi_valid,
    output logic [8*MAX_INSN_BYTES-1:0] z80fi_insn,
    output logic [2:0]                  z80fi_insn_len,
    output logic [7:0]                  z80fi_reg_a_in,
    output logic [7:0]                  z80fi_reg_f_in,
    output logic [15:0]                 z80fi_reg_ip_in,
    output logic [7:0]                  z80fi_reg_a_out,
    output logic [7:0]                  z80fi_reg_f_out,
    output logic [15:0]                 z80fi_reg_ip_out,
    output logic [3*MAX_MCYCLES-1:0]    z80fi_mcycle_types,
    output logic [4*MAX_MCYCLES-1:0]    z80fi_tcycles,
    output logic                        z80fi_overflow
);
    localparam int BW = 8 * MAX_INSN_BYTES;
    localparam int TW = 3 * MAX_MCYCLES;
    localparam int CW = 4 * MAX_MCYCLES;
    // slot index runs 0..MAX_MCYCLES; MAX_MCYCLES+1 marks a dropped M-cycle whose ticks are ignored
    localparam int IW = $clog2(MAX_MCYCLES + 2);
    localparam logic [2:0] CYCLE_NONE = 3'd0;

    typedef enum logic {IDLE, CAPTURE} state_t;

    state_t          state_q, state_d;
    logic            act, retire_fire;
    logic [BW-1:0]   wk_insn, b_insn, nx_insn;
    logic [2:0]      wk_len, b_len, nx_len;
    logic [TW-1:0]   wk_types, b_types, nx_types;
    logic [CW-1:0]   wk_tcyc, b_tcyc, nx_tcyc;
    logic [IW-1:0]   wk_idx, b_idx, nx_idx, cur;
    logic            wk_ovf, b_ovf, nx_ovf;
    logic [7:0]      wk_a_in, wk_f_in;
    logic [15:0]     wk_ip_in;

    // state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // next state: a start always (re)enters capture, a retire in capture returns to idle
    always_comb begin
        state_d = instr_start ? CAPTURE :
                  (state_q == CAPTURE && instr_retire) ? IDLE : state_q;
    end

    // FSM outputs: events are accepted while capturing or on the cycle a new instruction starts
    always_comb begin
        act         = instr_start || state_q == CAPTURE;
        retire_fire = state_q == CAPTURE && instr_retire;
    end

    // next working record: cleared on start, then this cycle's byte/M-cycle/tick applied
    always_comb begin
        b_insn   = instr_start ? '0 : wk_insn;
        b_len    = instr_start ? '0 : wk_len;
        b_types  = instr_start ? {MAX_MCYCLES{CYCLE_NONE}} : wk_types;
        b_tcyc   = instr_start ? '0 : wk_tcyc;
        b_idx    = instr_start ? '0 : wk_idx;
        b_ovf    = instr_start ? 1'b0 : wk_ovf;
        nx_insn  = b_insn;
        nx_len   = b_len;
        nx_types = b_types;
        nx_tcyc  = b_tcyc;
        nx_idx   = b_idx;
        nx_ovf   = b_ovf;
        if (act && insn_byte_valid) begin
            if (int'(b_len) < MAX_INSN_BYTES)
                nx_len = b_len + 3'd1;
            else
                nx_ovf = 1'b1;
            for (int k = 0; k < MAX_INSN_BYTES; k++)
                if (b_len == 3'(k))
                    nx_insn[8*k +: 8] = insn_byte;
        end
        if (act && mcycle_start) begin
            nx_idx = (int'(b_idx) < MAX_MCYCLES) ? b_idx + IW'(1) : IW'(MAX_MCYCLES + 1);
            nx_ovf = nx_ovf | (int'(b_idx) >= MAX_MCYCLES);
            for (int k = 0; k < MAX_MCYCLES; k++)
                if (b_idx == IW'(k))
                    nx_types[3*k +: 3] = mcycle_type;
        end
        cur = (nx_idx == '0) ? '0 : nx_idx - IW'(1);
        for (int k = 0; k < MAX_MCYCLES; k++)
            if (act && tstate_tick && nx_idx <= IW'(MAX_MCYCLES) && cur == IW'(k) &&
                nx_tcyc[4*k +: 4] != 4'hf)
                nx_tcyc[4*k +: 4] = nx_tcyc[4*k +: 4] + 4'd1;
    end

    // working buffers track the record under construction; in-regs latch at start
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wk_insn  <= '0;
            wk_len   <= '0;
            wk_types <= {MAX_MCYCLES{CYCLE_NONE}};
            wk_tcyc  <= '0;
            wk_idx   <= '0;
            wk_ovf   <= 1'b0;
            wk_a_in  <= '0;
            wk_f_in  <= '0;
            wk_ip_in <= '0;
        end else begin
            wk_insn  <= nx_insn;
            wk_len   <= nx_len;
            wk_types <= nx_types;
            wk_tcyc  <= nx_tcyc;
            wk_idx   <= nx_idx;
            wk_ovf   <= nx_ovf;
            if (instr_start) begin
                wk_a_in  <= reg_a;
                wk_f_in  <= reg_f;
                wk_ip_in <= reg_ip;
            end
        end
    end

    // output record loads only at retire; a coincident start's events belong to the new record
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            z80fi_valid        <= 1'b0;
            z80fi_insn         <= '0;
            z80fi_insn_len     <= '0;
            z80fi_reg_a_in     <= '0;
            z80fi_reg_f_in     <= '0;
            z80fi_reg_ip_in    <= '0;
            z80fi_reg_a_out    <= '0;
            z80fi_reg_f_out    <= '0;
            z80fi_reg_ip_out   <= '0;
            z80fi_mcycle_types <= {MAX_MCYCLES{CYCLE_NONE}};
            z80fi_tcycles      <= '0;
            z80fi_overflow     <= 1'b0;
        end else begin
            z80fi_valid <= retire_fire;
            if (retire_fire) begin
                z80fi_insn         <= instr_start ? wk_insn  : nx_insn;
                z80fi_insn_len     <= instr_start ? wk_len   : nx_len;
                z80fi_mcycle_types <= instr_start ? wk_types : nx_types;
                z80fi_tcycles      <= instr_start ? wk_tcyc  : nx_tcyc;
                z80fi_overflow     <= instr_start ? wk_ovf   : nx_ovf;
                z80fi_reg_a_in     <= wk_a_in;
                z80fi_reg_f_in     <= wk_f_in;
                z80fi_reg_ip_in    <= wk_ip_in;
                z80fi_reg_a_out    <= reg_a;
                z80fi_reg_f_out    <= reg_f;
                z80fi_reg_ip_out   <= reg_ip;
            end
        end
    end
endmodule
